// File: rtl/ahb2wb_pkg.sv
// Shared encodings for the AHB-to-Wishbone burst bridge: AHB transfer/burst/response
// codes, Wishbone cycle-type codes, and the bridge FSM state.
package ahb2wb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR = 2'b00;
    localparam logic [1:0] BTE_WRAP4  = 2'b01;
    localparam logic [1:0] BTE_WRAP8  = 2'b10;
    localparam logic [1:0] BTE_WRAP16 = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WB,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } state_t;

    // Fixed-length bursts are the ones with a non-zero length field in hburst[2:1].
    function automatic logic [4:0] burst_beats(input logic [2:0] burst);
        case (burst[2:1])
            2'b01:   burst_beats = 5'd4;
            2'b10:   burst_beats = 5'd8;
            2'b11:   burst_beats = 5'd16;
            default: burst_beats = 5'd0;
        endcase
    endfunction

    function automatic logic [1:0] burst_bte(input logic [2:0] burst);
        case (burst)
            HBURST_WRAP4:  burst_bte = BTE_WRAP4;
            HBURST_WRAP8:  burst_bte = BTE_WRAP8;
            HBURST_WRAP16: burst_bte = BTE_WRAP16;
            default:       burst_bte = BTE_LINEAR;
        endcase
    endfunction

endpackage

// File: rtl/ahb2wb_bytesel.sv
// Little-endian byte-lane decoder: maps hsize and the low address bits to Wishbone
// sel lanes, and flags sizes wider than the data bus.
module ahb2wb_bytesel #(
    parameter int DWIDTH = 32
) (
    input  logic [2:0]                       hsize,
    input  logic [$clog2(DWIDTH/8)-1:0]      addr_lo,
    output logic [DWIDTH/8-1:0]              sel,
    output logic                             size_err
);

    localparam int LANES = DWIDTH / 8;
    localparam int LB    = $clog2(LANES);

    always_comb begin
        sel      = '0;
        size_err = (32'(hsize) > LB);
        // A lane is enabled when it sits in the same size-aligned window as the address.
        for (int i = 0; i < LANES; i++) begin
            if ((i >> hsize) == (32'(addr_lo) >> hsize))
                sel[i] = 1'b1;
        end
        if (size_err)
            sel = '0;
    end

endmodule

// File: rtl/ahb2wb_burst.sv
// AHB-Lite slave to Wishbone B4 registered-feedback master bridge with burst
// cycle-type signalling, error/timeout abort and byte-lane decode.
module ahb2wb_burst
    import ahb2wb_pkg::*;
#(
    parameter int AWIDTH  = 16,
    parameter int DWIDTH  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                  hclk,
    input  logic                  rst_i,
    input  logic                  hsel,
    input  logic [AWIDTH-1:0]     haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [2:0]            hburst,
    input  logic [DWIDTH-1:0]     hwdata,
    output logic [DWIDTH-1:0]     hrdata,
    output logic                  hready,
    output logic [1:0]            hresp,
    output logic [AWIDTH-1:0]     adr_o,
    output logic [DWIDTH-1:0]     dat_o,
    input  logic [DWIDTH-1:0]     dat_i,
    output logic                  we_o,
    output logic [DWIDTH/8-1:0]   sel_o,
    output logic                  cyc_o,
    output logic                  stb_o,
    output logic [2:0]            cti_o,
    output logic [1:0]            bte_o,
    input  logic                  ack_i,
    input  logic                  err_i
);

    localparam int LANES = DWIDTH / 8;
    localparam int LB    = $clog2(LANES);
    localparam int TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t           state;
    logic [4:0]       beat_cnt;
    logic [TW-1:0]    tmo_cnt;
    logic [LANES-1:0] sel_dec;
    logic             size_err;
    logic             accept;
    logic             fixed_burst;
    logic [4:0]       beat_now;
    logic             tmo_hit;

    ahb2wb_bytesel #(.DWIDTH(DWIDTH)) u_bytesel (
        .hsize    (hsize),
        .addr_lo  (haddr[LB-1:0]),
        .sel      (sel_dec),
        .size_err (size_err)
    );

    assign dat_o       = hwdata;
    assign accept      = hsel && hready && htrans[1];
    assign fixed_burst = (hburst[2:1] != 2'b00);
    // NONSEQ restarts the beat count, which also handles early burst termination.
    assign beat_now    = (htrans == HTRANS_NONSEQ) ? burst_beats(hburst) : beat_cnt;
    assign tmo_hit     = (TIMEOUT != 0) && (tmo_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge hclk) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            beat_cnt <= '0;
            tmo_cnt  <= '0;
            hready   <= 1'b1;
            hresp    <= HRESP_OKAY;
            hrdata   <= '0;
            adr_o    <= '0;
            we_o     <= 1'b0;
            sel_o    <= '0;
            cyc_o    <= 1'b0;
            stb_o    <= 1'b0;
            cti_o    <= CTI_CLASSIC;
            bte_o    <= BTE_LINEAR;
        end else begin
            case (state)
                ST_WB: begin
                    if (err_i || tmo_hit) begin
                        state    <= ST_ERR1;
                        hresp    <= HRESP_ERROR;
                        cyc_o    <= 1'b0;
                        stb_o    <= 1'b0;
                        beat_cnt <= '0;
                    end else if (ack_i) begin
                        state  <= ST_DONE;
                        hready <= 1'b1;
                        stb_o  <= 1'b0;
                        cyc_o  <= (beat_cnt > 5'd1);
                        if (beat_cnt != 5'd0)
                            beat_cnt <= beat_cnt - 5'd1;
                        if (!we_o)
                            hrdata <= dat_i;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_ERR1: begin
                    state  <= ST_ERR2;
                    hready <= 1'b1;
                end
                default: begin
                    // IDLE, DONE and ERR2 all present hready=1 and may take a new transfer.
                    if (accept) begin
                        adr_o <= haddr;
                        we_o  <= hwrite;
                        sel_o <= sel_dec;
                        bte_o <= burst_bte(hburst);
                        hresp <= HRESP_OKAY;
                        if (!fixed_burst)
                            cti_o <= CTI_CLASSIC;
                        else if (beat_now == 5'd1)
                            cti_o <= CTI_EOB;
                        else
                            cti_o <= CTI_INCR;
                        if (htrans == HTRANS_NONSEQ)
                            beat_cnt <= burst_beats(hburst);
                        hready <= 1'b0;
                        if (size_err) begin
                            state    <= ST_ERR1;
                            hresp    <= HRESP_ERROR;
                            cyc_o    <= 1'b0;
                            stb_o    <= 1'b0;
                            beat_cnt <= '0;
                        end else begin
                            state   <= ST_WB;
                            cyc_o   <= 1'b1;
                            stb_o   <= 1'b1;
                            tmo_cnt <= '0;
                        end
                    end else begin
                        state <= ST_IDLE;
                        hresp <= HRESP_OKAY;
                        if (!hsel || htrans == HTRANS_IDLE)
                            cyc_o <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb2wb_burst.sv
// Directed bench for ahb2wb_burst: single, byte, INCR4/WRAP4 bursts, error, timeout,
// oversize, early ack, ack+err priority and mid-transfer reset.
module tb_ahb2wb_burst;
    import ahb2wb_pkg::*;

    logic        hclk = 1'b0;
    logic        rst_i;
    logic        hsel;
    logic [15:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic [1:0]  hresp;
    logic [15:0] adr_o;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic        we_o;
    logic [3:0]  sel_o;
    logic        cyc_o;
    logic        stb_o;
    logic [2:0]  cti_o;
    logic [1:0]  bte_o;
    logic        ack_i;
    logic        err_i;

    int checks = 0;
    int errors = 0;

    always #5 hclk = ~hclk;

    ahb2wb_burst #(.AWIDTH(16), .DWIDTH(32), .TIMEOUT(16)) dut (
        .hclk(hclk), .rst_i(rst_i), .hsel(hsel), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
        .hrdata(hrdata), .hready(hready), .hresp(hresp), .adr_o(adr_o),
        .dat_o(dat_o), .dat_i(dat_i), .we_o(we_o), .sel_o(sel_o), .cyc_o(cyc_o),
        .stb_o(stb_o), .cti_o(cti_o), .bte_o(bte_o), .ack_i(ack_i), .err_i(err_i)
    );

    task automatic tick;
        @(posedge hclk);
        #1;
    endtask

    task automatic drive_addr(input logic [1:0] tr, input logic [15:0] a, input logic wr,
                              input logic [2:0] sz, input logic [2:0] bu);
        hsel = 1'b1; htrans = tr; haddr = a; hwrite = wr; hsize = sz; hburst = bu;
    endtask

    task automatic drive_idle;
        htrans = HTRANS_IDLE;
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        drive_idle();
        tick(); tick();
        checks++; if ({hready, hresp, cyc_o, stb_o, we_o} !== 6'b100000) begin errors++;
            $display("FAIL reset_ctl: got %b expected 100000", {hready, hresp, cyc_o, stb_o, we_o}); end
        checks++; if (adr_o !== 16'h0) begin errors++; $display("FAIL reset_adr: got %h expected 0000", adr_o); end
        checks++; if (sel_o !== 4'h0) begin errors++; $display("FAIL reset_sel: got %b expected 0000", sel_o); end
        checks++; if ({cti_o, bte_o} !== 5'b0) begin errors++; $display("FAIL reset_cti_bte: got %b expected 00000", {cti_o, bte_o}); end
        checks++; if (hrdata !== 32'h0) begin errors++; $display("FAIL reset_hrdata: got %h expected 0", hrdata); end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_single_write;
        drive_addr(HTRANS_NONSEQ, 16'h0004, 1'b1, 3'd2, HBURST_SINGLE);
        tick();
        drive_idle();
        hwdata = 32'h12345678;
        ack_i  = 1'b1;
        #1;
        checks++; if ({stb_o, cyc_o, hready, we_o} !== 4'b1101) begin errors++;
            $display("FAIL sw_wb_ctl: got %b expected 1101", {stb_o, cyc_o, hready, we_o}); end
        checks++; if (adr_o !== 16'h0004) begin errors++; $display("FAIL sw_adr: got %h expected 0004", adr_o); end
        checks++; if (sel_o !== 4'b1111) begin errors++; $display("FAIL sw_sel: got %b expected 1111", sel_o); end
        checks++; if (dat_o !== 32'h12345678) begin errors++; $display("FAIL sw_dat: got %h expected 12345678", dat_o); end
        checks++; if (cti_o !== 3'b000) begin errors++; $display("FAIL sw_cti: got %b expected 000", cti_o); end
        tick();
        ack_i = 1'b0;
        checks++; if ({stb_o, cyc_o, hready, hresp} !== 5'b00100) begin errors++;
            $display("FAIL sw_done: got %b expected 00100", {stb_o, cyc_o, hready, hresp}); end
        tick();
    endtask

    task automatic test_byte_read;
        drive_addr(HTRANS_NONSEQ, 16'h0006, 1'b0, 3'd0, HBURST_SINGLE);
        tick();
        drive_idle();
        checks++; if (sel_o !== 4'b0100) begin errors++; $display("FAIL br_sel: got %b expected 0100", sel_o); end
        checks++; if ({cti_o, we_o, stb_o} !== 5'b00001) begin errors++;
            $display("FAIL br_ctl: got %b expected 00001", {cti_o, we_o, stb_o}); end
        dat_i = 32'hAABBCCDD;
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        dat_i = 32'h0;
        checks++; if (hrdata !== 32'hAABBCCDD) begin errors++; $display("FAIL br_hrdata: got %h expected aabbccdd", hrdata); end
        checks++; if (hready !== 1'b1) begin errors++; $display("FAIL br_hready: got %b expected 1", hready); end
        tick();
    endtask

    task automatic test_incr4_write;
        for (int i = 0; i < 4; i++) begin
            drive_addr((i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 16'h0010 + 16'(4 * i), 1'b1, 3'd2, HBURST_INCR4);
            tick();
            hwdata = 32'h1000_0000 + 32'(i);
            ack_i  = 1'b1;
            #1;
            checks++; if (cti_o !== ((i == 3) ? 3'b111 : 3'b010)) begin errors++;
                $display("FAIL incr4_cti beat %0d: got %b expected %b", i, cti_o, (i == 3) ? 3'b111 : 3'b010); end
            checks++; if ({adr_o, cyc_o, stb_o, bte_o} !== {16'h0010 + 16'(4 * i), 2'b11, 2'b00}) begin errors++;
                $display("FAIL incr4_wb beat %0d: got %h/%b%b/%b", i, adr_o, cyc_o, stb_o, bte_o); end
            tick();
            ack_i = 1'b0;
            checks++; if ({cyc_o, hready} !== {(i < 3), 1'b1}) begin errors++;
                $display("FAIL incr4_done beat %0d: got cyc %b hready %b expected cyc %b hready 1", i, cyc_o, hready, i < 3); end
        end
        drive_idle();
        tick();
    endtask

    task automatic test_wrap4_read;
        for (int i = 0; i < 4; i++) begin
            drive_addr((i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 16'h0010 | 16'(((i + 2) % 4) * 4), 1'b0, 3'd2, HBURST_WRAP4);
            tick();
            checks++; if ({adr_o, bte_o, cti_o} !== {16'h0010 | 16'(((i + 2) % 4) * 4), 2'b01, (i == 3) ? 3'b111 : 3'b010}) begin errors++;
                $display("FAIL wrap4_wb beat %0d: got adr %h bte %b cti %b", i, adr_o, bte_o, cti_o); end
            dat_i = 32'hC0DE_0000 + 32'(i);
            ack_i = 1'b1;
            tick();
            ack_i = 1'b0;
            checks++; if (hrdata !== 32'hC0DE_0000 + 32'(i)) begin errors++;
                $display("FAIL wrap4_hrdata beat %0d: got %h expected %h", i, hrdata, 32'hC0DE_0000 + 32'(i)); end
        end
        drive_idle();
        tick();
    endtask

    task automatic test_err_beat2;
        drive_addr(HTRANS_NONSEQ, 16'h0020, 1'b1, 3'd2, HBURST_INCR4);
        tick();
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        drive_addr(HTRANS_SEQ, 16'h0024, 1'b1, 3'd2, HBURST_INCR4);
        tick();
        err_i = 1'b1;
        tick();
        err_i = 1'b0;
        drive_idle();
        checks++; if ({hresp, hready, cyc_o, stb_o} !== 5'b01000) begin errors++;
            $display("FAIL err_err1: got %b expected 01000", {hresp, hready, cyc_o, stb_o}); end
        tick();
        checks++; if ({hresp, hready, cyc_o} !== 4'b0110) begin errors++;
            $display("FAIL err_err2: got %b expected 0110", {hresp, hready, cyc_o}); end
        tick();
        checks++; if ({hresp, hready} !== 3'b001) begin errors++;
            $display("FAIL err_idle: got %b expected 001", {hresp, hready}); end
    endtask

    task automatic test_timeout;
        drive_addr(HTRANS_NONSEQ, 16'h0030, 1'b0, 3'd2, HBURST_SINGLE);
        tick();
        drive_idle();
        for (int k = 1; k < 16; k++) begin
            tick();
            checks++; if ({stb_o, hready} !== 2'b10) begin errors++;
                $display("FAIL tmo_wait cycle %0d: got %b expected 10", k + 1, {stb_o, hready}); end
        end
        tick();
        checks++; if ({hresp, hready, cyc_o, stb_o} !== 5'b01000) begin errors++;
            $display("FAIL tmo_err1: got %b expected 01000", {hresp, hready, cyc_o, stb_o}); end
        tick();
        checks++; if ({hresp, hready} !== 3'b011) begin errors++;
            $display("FAIL tmo_err2: got %b expected 011", {hresp, hready}); end
        tick();
    endtask

    task automatic test_size_err;
        drive_addr(HTRANS_NONSEQ, 16'h0038, 1'b0, 3'd3, HBURST_SINGLE);
        tick();
        drive_idle();
        checks++; if ({hresp, hready, cyc_o, stb_o} !== 5'b01000) begin errors++;
            $display("FAIL size_err1: got %b expected 01000", {hresp, hready, cyc_o, stb_o}); end
        tick();
        checks++; if ({hresp, hready, cyc_o} !== 4'b0110) begin errors++;
            $display("FAIL size_err2: got %b expected 0110", {hresp, hready, cyc_o}); end
        tick();
    endtask

    task automatic test_ack_corner;
        ack_i = 1'b1;
        dat_i = 32'h0000_0055;
        drive_addr(HTRANS_NONSEQ, 16'h0040, 1'b0, 3'd2, HBURST_SINGLE);
        tick();
        drive_idle();
        checks++; if ({stb_o, hready} !== 2'b10) begin errors++;
            $display("FAIL early_ack_wb: got %b expected 10", {stb_o, hready}); end
        tick();
        ack_i = 1'b0;
        checks++; if ({hready, hresp, hrdata} !== {3'b100, 32'h0000_0055}) begin errors++;
            $display("FAIL early_ack_done: got %b %h expected 100 00000055", {hready, hresp}, hrdata); end
        tick();
        drive_addr(HTRANS_NONSEQ, 16'h0044, 1'b1, 3'd2, HBURST_SINGLE);
        tick();
        drive_idle();
        ack_i = 1'b1;
        err_i = 1'b1;
        tick();
        ack_i = 1'b0;
        err_i = 1'b0;
        checks++; if ({hresp, hready} !== 3'b010) begin errors++;
            $display("FAIL ack_err_prio: got %b expected 010", {hresp, hready}); end
        tick(); tick();
    endtask

    task automatic test_reset_mid;
        drive_addr(HTRANS_NONSEQ, 16'h0050, 1'b1, 3'd2, HBURST_SINGLE);
        tick();
        checks++; if (stb_o !== 1'b1) begin errors++; $display("FAIL rmid_pre: got stb %b expected 1", stb_o); end
        rst_i = 1'b1;
        drive_idle();
        tick();
        rst_i = 1'b0;
        checks++; if ({hready, hresp, cyc_o, stb_o, we_o, sel_o, cti_o, bte_o} !== 15'b100000_0000_00000) begin errors++;
            $display("FAIL rmid_ctl: got %b expected 100000000000000", {hready, hresp, cyc_o, stb_o, we_o, sel_o, cti_o, bte_o}); end
        checks++; if ({adr_o, hrdata} !== 48'h0) begin errors++;
            $display("FAIL rmid_data: got adr %h hrdata %h expected 0", adr_o, hrdata); end
        drive_addr(HTRANS_NONSEQ, 16'h0008, 1'b1, 3'd2, HBURST_SINGLE);
        tick();
        drive_idle();
        hwdata = 32'hCAFEF00D;
        ack_i  = 1'b1;
        #1;
        checks++; if ({adr_o, stb_o, we_o, dat_o} !== {16'h0008, 2'b11, 32'hCAFEF00D}) begin errors++;
            $display("FAIL rmid_wr_wb: got adr %h stb %b we %b dat %h", adr_o, stb_o, we_o, dat_o); end
        tick();
        ack_i = 1'b0;
        checks++; if ({hready, hresp, stb_o} !== 4'b1000) begin errors++;
            $display("FAIL rmid_wr_done: got %b expected 1000", {hready, hresp, stb_o}); end
        tick();
    endtask

    initial begin
        rst_i = 1'b1; hsel = 1'b0; haddr = '0; htrans = HTRANS_IDLE; hwrite = 1'b0;
        hsize = 3'd2; hburst = HBURST_SINGLE; hwdata = '0; dat_i = '0; ack_i = 1'b0; err_i = 1'b0;
        test_reset();
        test_single_write();
        test_byte_read();
        test_incr4_write();
        test_wrap4_read();
        test_err_beat2();
        test_timeout();
        test_size_err();
        test_ack_corner();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

endmodule
